// File: rtl/riscv_pmp_req_gate.sv
// riscv_pmp_req_gate
// Gates upstream memory requests with the same-cycle PMP verdict. Permitted
// accesses are forwarded to the BIU one at a time; denied accesses never reach
// the bus and get an immediate PMP-fault response. A flush abandons the
// current access and suppresses its response, draining any bus reply still owed.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   flush_i                 abort current access, suppress its response
//   req_i / req_ready_o     upstream request handshake
//   adr_i, size_i, we_i, d_i, pmp_exception_i   request payload + PMP verdict
//   biu_stb_o / biu_stb_ack_i                   BIU strobe handshake
//   biu_adr_o, biu_size_o, biu_we_o, biu_d_o    registered BIU payload
//   biu_ack_i, biu_err_i, biu_q_i               BIU completion
//   rsp_valid_o, rsp_q_o, rsp_err_o, rsp_pmp_fault_o  response
//   fault_adr_o             address of the last PMP-faulting request
module riscv_pmp_req_gate #(
    parameter int XLEN = 32,
    parameter int PLEN = (XLEN == 32) ? 34 : 56
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            req_i,
    output logic            req_ready_o,
    input  logic [PLEN-1:0] adr_i,
    input  logic [2:0]      size_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] d_i,
    input  logic            pmp_exception_i,
    output logic            biu_stb_o,
    input  logic            biu_stb_ack_i,
    output logic [PLEN-1:0] biu_adr_o,
    output logic [2:0]      biu_size_o,
    output logic            biu_we_o,
    output logic [XLEN-1:0] biu_d_o,
    input  logic            biu_ack_i,
    input  logic            biu_err_i,
    input  logic [XLEN-1:0] biu_q_i,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_q_o,
    output logic            rsp_err_o,
    output logic            rsp_pmp_fault_o,
    output logic [PLEN-1:0] fault_adr_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_RSP
    } state_t;

    state_t r_state;
    logic   w_accept;
    logic   w_bus_done;

    assign req_ready_o = (r_state == S_IDLE) & ~flush_i;
    assign w_accept    = req_i & req_ready_o;
    assign w_bus_done  = biu_ack_i | biu_err_i;
    // A flush arriving in the response cycle still swallows the response.
    assign rsp_valid_o = (r_state == S_RSP) & ~flush_i;

    // Access sequencer with registered BIU and response outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state         <= S_IDLE;
            biu_stb_o       <= 1'b0;
            biu_adr_o       <= '0;
            biu_size_o      <= '0;
            biu_we_o        <= 1'b0;
            biu_d_o         <= '0;
            rsp_q_o         <= '0;
            rsp_err_o       <= 1'b0;
            rsp_pmp_fault_o <= 1'b0;
            fault_adr_o     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (pmp_exception_i) begin
                            fault_adr_o     <= adr_i;
                            rsp_pmp_fault_o <= 1'b1;
                            rsp_err_o       <= 1'b0;
                            rsp_q_o         <= '0;
                            r_state         <= S_RSP;
                        end else begin
                            biu_adr_o  <= adr_i;
                            biu_size_o <= size_i;
                            biu_we_o   <= we_i;
                            biu_d_o    <= d_i;
                            biu_stb_o  <= 1'b1;
                            r_state    <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (flush_i) begin
                        biu_stb_o <= 1'b0;
                        // Unaccepted strobe can simply be withdrawn; an accepted
                        // one owes a reply unless that reply already arrived.
                        if (!biu_stb_ack_i || w_bus_done) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (biu_stb_ack_i) begin
                        biu_stb_o <= 1'b0;
                        if (w_bus_done) begin
                            rsp_q_o         <= biu_q_i;
                            rsp_err_o       <= biu_err_i;
                            rsp_pmp_fault_o <= 1'b0;
                            r_state         <= S_RSP;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (flush_i) begin
                        r_state <= w_bus_done ? S_IDLE : S_DRAIN;
                    end else if (w_bus_done) begin
                        rsp_q_o         <= biu_q_i;
                        rsp_err_o       <= biu_err_i;
                        rsp_pmp_fault_o <= 1'b0;
                        r_state         <= S_RSP;
                    end
                end
                S_DRAIN: begin
                    if (w_bus_done) begin
                        r_state <= S_IDLE;
                    end
                end
                S_RSP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
